mult_div_ctrl: RTL and testbench

//  Iterative multiply/divide unit (MDU) controller for the EX stage, beside the ALU.

---
 rtl/mult_div_ctrl_pkg.sv | 36 +++
 rtl/mult_div_ctrl_iter_core.sv | 89 ++++++++
 rtl/mult_div_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: funct encodings, FSM states
// and small decode helpers used by the controller and the instruction decoder.
package mult_div_ctrl_pkg;

   localparam int MDU_NB_FUNCT = 6;

   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_MULT  = 6'b011000;
   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_MULTU = 6'b011001;
   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_DIV   = 6'b011010;
   localparam logic [MDU_NB_FUNCT-1:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic is_muldiv(input logic [MDU_NB_FUNCT-1:0] funct);
      return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
             (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [MDU_NB_FUNCT-1:0] funct);
      return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [MDU_NB_FUNCT-1:0] funct);
      return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
   endfunction

endpackage

// File: rtl/mult_div_ctrl_iter_core.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
// One bit per step; sign correction is applied combinationally while i_fix is high.
module mult_div_ctrl_iter_core #(
   parameter int NB_DATA = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic               i_step,
   input  logic               i_fix,
   input  logic               i_is_div,
   input  logic               i_neg_res,
   input  logic               i_neg_rem,
   input  logic [NB_DATA-1:0] i_opa,
   input  logic [NB_DATA-1:0] i_opb,
   output logic [NB_DATA-1:0] o_hi,
   output logic [NB_DATA-1:0] o_lo
);

   logic [NB_DATA-1:0]   acc_q, acc_d;
   logic [NB_DATA-1:0]   lo_q, lo_d;
   logic [NB_DATA-1:0]   opb_q, opb_d;
   logic                 is_div_q, is_div_d;

   logic [NB_DATA-1:0]   mul_addend;
   logic [NB_DATA:0]     mul_sum;
   logic [NB_DATA:0]     div_shift;
   logic                 div_ge;
   logic [NB_DATA-1:0]   div_sub;
   logic [2*NB_DATA-1:0] prod_neg;

   // acc holds the running product high half (mul) or partial remainder (div);
   // lo holds the multiplier shifting out (mul) or dividend shifting into quotient (div).
   always_comb begin
      mul_addend = lo_q[0] ? opb_q : '0;
      mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
      div_shift  = {acc_q, lo_q[NB_DATA-1]};
      div_ge     = (div_shift >= {1'b0, opb_q});
      div_sub    = div_shift[NB_DATA-1:0] - opb_q;

      acc_d    = acc_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      if (i_load) begin
         acc_d    = '0;
         lo_d     = i_opa;
         opb_d    = i_opb;
         is_div_d = i_is_div;
      end else if (i_step) begin
         if (is_div_q) begin
            acc_d = div_ge ? div_sub : div_shift[NB_DATA-1:0];
            lo_d  = {lo_q[NB_DATA-2:0], div_ge};
         end else begin
            acc_d = mul_sum[NB_DATA:1];
            lo_d  = {mul_sum[0], lo_q[NB_DATA-1:1]};
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         acc_q    <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
      end
   end

   always_comb begin
      prod_neg = -{acc_q, lo_q};
      o_hi     = acc_q;
      o_lo     = lo_q;
      if (i_fix) begin
         if (is_div_q) begin
            if (i_neg_res) o_lo = -lo_q;
            if (i_neg_rem) o_hi = -acc_q;
         end else if (i_neg_res) begin
            {o_hi, o_lo} = prod_neg;
         end
      end
   end

endmodule

// File: rtl/mult_div_ctrl.sv
// EX-stage multiply/divide controller: FSM, iteration counter, sign flags,
// architectural HI/LO and pipeline stall. Datapath lives in the iter core.
module mult_div_ctrl
   import mult_div_ctrl_pkg::*;
#(
   parameter int NB_DATA  = 32,
   parameter int NB_FUNCT = 6,
   parameter int NB_COUNT = $clog2(NB_DATA) + 1
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NB_FUNCT-1:0] i_funct,
   input  logic [NB_DATA-1:0]  i_rfile_rs,
   input  logic [NB_DATA-1:0]  i_rfile_rt,
   input  logic                i_flush,
   output logic                o_stall,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_div_zero,
   output logic [NB_DATA-1:0]  o_mf_result,
   output logic [NB_DATA-1:0]  o_hi,
   output logic [NB_DATA-1:0]  o_lo,
   output mdu_state_e          o_state
);

   localparam logic [NB_COUNT-1:0] LAST_STEP = NB_COUNT'(NB_DATA - 1);

   mdu_state_e          state_q, state_d;
   logic [NB_COUNT-1:0] count_q, count_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic                div_zero_q, div_zero_d;
   logic [NB_DATA-1:0]  hi_q, hi_d;
   logic [NB_DATA-1:0]  lo_q, lo_d;

   logic                idle_req;
   logic                accept_md;
   logic                div_zero_req;
   logic                rs_neg, rt_neg;
   logic [NB_DATA-1:0]  rs_mag, rt_mag;
   logic                core_load, core_step, core_fix;
   logic [NB_DATA-1:0]  core_hi, core_lo;

   // A request only acts in IDLE and is dropped when squashed in the same cycle.
   always_comb begin
      idle_req     = (state_q == ST_IDLE) && i_start && !i_flush;
      accept_md    = idle_req && is_muldiv(i_funct);
      div_zero_req = is_div_op(i_funct) && (i_rfile_rt == '0);
      rs_neg       = is_signed_op(i_funct) && i_rfile_rs[NB_DATA-1];
      rt_neg       = is_signed_op(i_funct) && i_rfile_rt[NB_DATA-1];
      rs_mag       = rs_neg ? -i_rfile_rs : i_rfile_rs;
      rt_mag       = rt_neg ? -i_rfile_rt : i_rfile_rt;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_md) state_d = div_zero_req ? ST_DONE : ST_CALC;
         end
         ST_CALC: begin
            if (i_flush)                 state_d = ST_IDLE;
            else if (count_q == LAST_STEP) state_d = ST_FIX;
         end
         ST_FIX:  state_d = i_flush ? ST_IDLE : ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy      = (state_q != ST_IDLE);
      o_done      = (state_q == ST_DONE);
      o_div_zero  = (state_q == ST_DONE) && div_zero_q;
      o_stall     = i_start && (state_q != ST_IDLE);
      core_load   = accept_md && !div_zero_req;
      core_step   = (state_q == ST_CALC);
      core_fix    = (state_q == ST_FIX);
      o_mf_result = '0;
      if (idle_req) begin
         if (i_funct == FUNCT_MFHI)      o_mf_result = hi_q;
         else if (i_funct == FUNCT_MFLO) o_mf_result = lo_q;
      end
   end

   // HI/LO change only on MTHI/MTLO, a divide-by-zero accept or an unflushed FIX.
   always_comb begin
      count_d    = count_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      if (accept_md) begin
         count_d    = '0;
         neg_res_d  = rs_neg ^ rt_neg;
         neg_rem_d  = rs_neg;
         div_zero_d = div_zero_req;
         if (div_zero_req) begin
            hi_d = i_rfile_rs;
            lo_d = '1;
         end
      end else if (core_step) begin
         count_d = count_q + NB_COUNT'(1);
      end
      if (idle_req && (i_funct == FUNCT_MTHI)) hi_d = i_rfile_rs;
      if (idle_req && (i_funct == FUNCT_MTLO)) lo_d = i_rfile_rs;
      if (core_fix && !i_flush) begin
         hi_d = core_hi;
         lo_d = core_lo;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         count_q    <= '0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         count_q    <= count_d;
         neg_res_q  <= neg_res_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   mult_div_ctrl_iter_core #(
      .NB_DATA (NB_DATA)
   ) u_iter_core (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_load    (core_load),
      .i_step    (core_step),
      .i_fix     (core_fix),
      .i_is_div  (is_div_op(i_funct)),
      .i_neg_res (neg_res_q),
      .i_neg_rem (neg_rem_q),
      .i_opa     (rs_mag),
      .i_opb     (rt_mag),
      .o_hi      (core_hi),
      .o_lo      (core_lo)
   );

   assign o_hi    = hi_q;
   assign o_lo    = lo_q;
   assign o_state = state_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed literal cases plus randomized traffic,
// every cycle compared against a cycle-counting arithmetic model.
module tb_mult_div_ctrl;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam int         OP_LAT  = 34;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [5:0]  funct;
   logic [31:0] rs, rt;
   logic        o_stall, o_busy, o_done, o_div_zero;
   logic [31:0] o_mf_result, o_hi, o_lo;
   logic [1:0]  o_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   bit          m_busy;
   int          m_end;
   bit          m_dz;
   logic [31:0] m_hi, m_lo;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   mult_div_ctrl dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_start     (start),
      .i_funct     (funct),
      .i_rfile_rs  (rs),
      .i_rfile_rt  (rt),
      .i_flush     (flush),
      .o_stall     (o_stall),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_div_zero  (o_div_zero),
      .o_mf_result (o_mf_result),
      .o_hi        (o_hi),
      .o_lo        (o_lo),
      .o_state     (o_state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural result {HI, LO} straight from integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b, output bit dz);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [31:0]     q, r;
      logic [63:0]     res;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      dz  = 1'b0;
      res = '0;
      if ((f == F_DIV || f == F_DIVU) && b == 32'd0) begin
         dz  = 1'b1;
         res = {a, 32'hFFFF_FFFF};
      end else if (f == F_MULT) begin
         res = 64'(sa * sb);
      end else if (f == F_MULTU) begin
         res = 64'(ua * ub);
      end else if (f == F_DIV) begin
         q   = 32'(sa / sb);
         r   = 32'(sa % sb);
         res = {r, q};
      end else begin
         q   = a / b;
         r   = a % b;
         res = {r, q};
      end
      return res;
   endfunction

   task automatic model_step();
      bit          dz;
      logic [63:0] res;
      if (rst) begin
         m_busy = 0;
         m_hi   = '0;
         m_lo   = '0;
         exp_q.delete();
      end else if (m_busy) begin
         if (flush) begin
            m_busy = 0;
            exp_q.delete();
         end else if (cyc == m_end - 1) begin
            {m_hi, m_lo} = exp_q.pop_front();
         end else if (cyc == m_end) begin
            m_busy = 0;
         end
      end else if (start && !flush) begin
         if (funct == F_MTHI) m_hi = rs;
         if (funct == F_MTLO) m_lo = rs;
         if (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU) begin
            res    = ref_result(funct, rs, rt, dz);
            m_busy = 1;
            m_dz   = dz;
            if (dz) begin
               m_end        = cyc + 1;
               {m_hi, m_lo} = res;
            end else begin
               m_end = cyc + OP_LAT;
               exp_q.push_back(res);
            end
         end
      end
      cyc++;
   endtask

   task automatic compare_step();
      bit          exp_done;
      logic [31:0] exp_mf;
      exp_done = m_busy && (cyc == m_end);
      exp_mf   = '0;
      if (!m_busy && start && !flush) begin
         if (funct == F_MFHI) exp_mf = m_hi;
         if (funct == F_MFLO) exp_mf = m_lo;
      end
      chk("busy", o_busy, m_busy);
      chk("done", o_done, exp_done);
      chk("div_zero", o_div_zero, exp_done && m_dz);
      chk("stall", o_stall, start && m_busy);
      chk("hi", o_hi, m_hi);
      chk("lo", o_lo, m_lo);
      chk("mf_result", o_mf_result, exp_mf);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic fl);
      start = s;
      funct = f;
      rs    = a;
      rt    = b;
      flush = fl;
   endtask

   task automatic wait_done(output int lat, output logic dz);
      bit seen;
      seen = 0;
      lat  = 0;
      dz   = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (o_done) begin
            seen = 1;
            dz   = o_div_zero;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic exp_dz,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int   lat;
      logic dz;
      drive(1'b1, f, a, b, 1'b0);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      wait_done(lat, dz);
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_div_zero"}, dz, exp_dz);
      chk({name, "_hi"}, o_hi, exp_hi);
      chk({name, "_lo"}, o_lo, exp_lo);
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [5:0] ftab [8];
      int         n;
      bit         free;
      ftab[0] = F_MFHI;  ftab[1] = F_MTHI;  ftab[2] = F_MFLO; ftab[3] = F_MTLO;
      ftab[4] = F_MULT;  ftab[5] = F_MULTU; ftab[6] = F_DIV;  ftab[7] = F_DIVU;

      rst    = 1'b1;
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      m_busy = 0;
      m_end  = 0;
      m_dz   = 0;
      m_hi   = '0;
      m_lo   = '0;

      fork
         forever begin
            @(posedge clk);
            model_step();
         end
         forever begin
            @(negedge clk);
            compare_step();
         end
      join_none

      repeat (3) step();
      rst = 1'b0;
      chk("reset_hi", o_hi, 32'd0);
      chk("reset_lo", o_lo, 32'd0);
      chk("reset_busy", o_busy, 1'b0);

      run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 34, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 34, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_intmin", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b0, 32'h0, 32'h8000_0000);
      run_op("divu_zero", F_DIVU, 32'd7, 32'd0, 1, 1'b1, 32'd7, 32'hFFFF_FFFF);

      // MFLO issued at cycle 5 of a MULT must stall through cycle 34.
      drive(1'b1, F_MULT, 32'd5, 32'd6, 1'b0);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      repeat (4) step();
      drive(1'b1, F_MFLO, 32'd0, 32'd0, 1'b0);
      n    = 0;
      free = 0;
      for (int i = 0; i < 100 && !free; i++) begin
         @(negedge clk);
         if (o_stall) begin
            if (n == 0) chk("lo_held_before_done", o_lo, 32'hFFFF_FFFF);
            n++;
            step();
         end else begin
            free = 1;
         end
      end
      chk("stall_cycles", 64'(n), 64'd30);
      chk("mflo_after_done", o_mf_result, 32'd30);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);

      // Flush at cycle 10 of a DIV.
      drive(1'b1, F_DIV, 32'd100, 32'd3, 1'b0);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      repeat (9) step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk("flush_idle", o_busy, 1'b0);
      chk("flush_hi_kept", o_hi, 32'd0);
      chk("flush_lo_kept", o_lo, 32'd30);
      step();

      drive(1'b1, F_MULT, 32'd2, 32'd3, 1'b1);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk("start_flush_ignored", o_busy, 1'b0);
      step();

      drive(1'b1, F_MTHI, 32'h1234_5678, 32'd0, 1'b0);
      step();
      drive(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      chk("mthi_mfhi", o_mf_result, 32'h1234_5678);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);

      // Reset in the middle of CALC.
      drive(1'b1, F_MULT, 32'd9, 32'd9, 1'b0);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midop_reset_hi", o_hi, 32'd0);
      chk("midop_reset_lo", o_lo, 32'd0);
      chk("midop_reset_busy", o_busy, 1'b0);
      step();

      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 499) == 0);
         start = $urandom_range(0, 1) != 0;
         funct = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ftab[$urandom_range(0, 7)];
         rs    = rand_op();
         rt    = rand_op();
         flush = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
      repeat (40) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
